hdr_ctrl: RTL and testbench
===========================

HDR_CTRL -- requirements
Module: hdr_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, pixel address width; H_RES*V_RES <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port frame_start, input, 1, single-cycle request to process one frame.
REQ-007 SHALL have port abort, input, 1, terminates the current frame.
REQ-008 SHALL have ports rd_req (output, 1), rd_exp (output, 2; 0=high, 1=mid, 2=low), rd_addr (output, ADDR_W) and rd_ack (input, 1), forming the exposure read request.
REQ-009 SHALL have port rd_data, input, 16, RGB565 pixel, valid when rd_ack=1.
REQ-010 SHALL have ports pix_high, pix_mid and pix_low, each output, 16, registered RGB565 operands to the HDR core.
REQ-011 SHALL have ports hdr_start (output, 1), hdr_done (input, 1) and hdr_le (input, 24, {red, green, blue}) for the HDR core handshake.
REQ-012 SHALL have ports wr_valid (output, 1), wr_addr (output, ADDR_W), wr_data (output, 24) and wr_ready (input, 1) for the result write.
REQ-013 SHALL have ports busy (output, 1), frame_done (output, 1 pulse) and err (output, 1 sticky).

Function
REQ-014 SHALL implement states IDLE, RD_H, RD_M, RD_L, START, WAIT, WRITE.
REQ-015 SHALL, in IDLE with frame_start=1, clear the pixel address to 0, set busy and enter RD_H on the next cycle.
REQ-016 SHALL ignore frame_start outside IDLE.
REQ-017 SHALL, in RD_H/RD_M/RD_L, hold rd_req=1 with rd_exp=0/1/2 and rd_addr equal to the pixel address, all stable until rd_ack.
REQ-018 SHALL capture rd_data into pix_high/pix_mid/pix_low on the rd_ack cycle and advance RD_H->RD_M->RD_L->START in the following cycle.
REQ-019 SHALL ignore rd_ack while rd_req=0.
REQ-020 SHALL assert hdr_start for exactly one cycle in START, then enter WAIT.
REQ-021 SHALL, in WAIT with hdr_done=1, register hdr_le into wr_data and wr_addr=pixel address, and enter WRITE.
REQ-022 SHALL hold wr_valid=1 in WRITE with wr_data and wr_addr stable until wr_ready=1.
REQ-023 SHALL, on the wr_ready cycle, either increment the address and enter RD_H, or, if address = H_RES*V_RES-1, pulse frame_done for one cycle, clear busy, wrap the address to 0 and enter IDLE.
REQ-024 SHALL, when abort=1 in any non-IDLE state, enter IDLE on the next cycle: deassert rd_req, hdr_start and wr_valid, clear busy, and not pulse frame_done; abort has priority over every simultaneous handshake.
REQ-025 SHALL keep a frame_start coincident with a final-pixel frame_done unserviced; a new frame needs frame_start while in IDLE.
REQ-026 SHALL drive every output from registers.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously set: state IDLE; address 0; rd_req, hdr_start, wr_valid, busy, frame_done and err 0; rd_exp 0; pix_* 0; wr_data 0; wr_addr 0; rd_addr 0.
REQ-028 SHALL, on reset mid-frame, drop all handshakes immediately and keep no partial frame state after release.

Configuration
REQ-029 SHALL, with macro HDR_CTRL_TIMEOUT_EN defined, run a 4-bit counter in WAIT; if hdr_done has not arrived within 15 cycles of hdr_start, set err=1 (sticky until reset) and enter IDLE with busy cleared.
REQ-030 SHALL, without HDR_CTRL_TIMEOUT_EN, wait in WAIT indefinitely, and err SHALL be constant 0.

Verification
REQ-031 SHALL cover: H_RES=2, V_RES=2, zero-wait rd_ack/wr_ready, hdr_done 3 cycles after hdr_start -> 4 writes, addresses 0..3, frame_done on the write-3 accept cycle, busy low next cycle.
REQ-032 SHALL cover: rd_ack delayed 5 cycles in RD_M -> rd_req, rd_exp=1 and rd_addr stable for all 5 cycles; pix_mid equals rd_data from the ack cycle.
REQ-033 SHALL cover: wr_ready low 7 cycles -> wr_valid, wr_data and wr_addr held; exactly one write accepted.
REQ-034 SHALL cover: abort in WAIT at pixel 1 -> IDLE next cycle, no frame_done, no write; a following frame_start restarts at address 0.
REQ-035 SHALL cover: frame_start pulsed while busy -> ignored; asynchronous reset in WRITE -> wr_valid 0 without waiting for a clock edge.
REQ-036 SHALL cover, with HDR_CTRL_TIMEOUT_EN: hdr_done withheld -> err=1 exactly 15 cycles after hdr_start, IDLE, err stays 1 until rst_n=0.

Source files
------------

// File: rtl/hdr_ctrl.sv
// HDR frame controller: fetches three exposures per pixel, runs the HDR core, writes the result.
// Optional HDR core watchdog enabled by defining HDR_CTRL_TIMEOUT_EN.
module hdr_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              abort,
  output logic              rd_req,
  output logic [1:0]        rd_exp,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [15:0]       rd_data,
  output logic [15:0]       pix_high,
  output logic [15:0]       pix_mid,
  output logic [15:0]       pix_low,
  output logic              hdr_start,
  input  logic              hdr_done,
  input  logic [23:0]       hdr_le,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [2:0] {IDLE, RD_H, RD_M, RD_L, START, WAIT, WRITE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic              cap_h, cap_m, cap_l, cap_w;
  logic              done_nx, err_nx;

`ifdef HDR_CTRL_TIMEOUT_EN
  logic [3:0] cnt;
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cap_h    = 1'b0;
    cap_m    = 1'b0;
    cap_l    = 1'b0;
    cap_w    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = err;
    case (state)
      // A start arriving alongside the frame_done pulse is deliberately dropped.
      IDLE: if (frame_start && !frame_done) begin
        addr_nx  = '0;
        state_nx = RD_H;
      end
      RD_H: if (rd_ack) begin
        cap_h    = 1'b1;
        state_nx = RD_M;
      end
      RD_M: if (rd_ack) begin
        cap_m    = 1'b1;
        state_nx = RD_L;
      end
      RD_L: if (rd_ack) begin
        cap_l    = 1'b1;
        state_nx = START;
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (hdr_done) begin
          cap_w    = 1'b1;
          state_nx = WRITE;
        end
`ifdef HDR_CTRL_TIMEOUT_EN
        else if (cnt == 4'd14) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      WRITE: if (wr_ready) begin
        if (addr == LAST) begin
          done_nx  = 1'b1;
          addr_nx  = '0;
          state_nx = IDLE;
        end else begin
          addr_nx  = addr + ADDR_W'(1);
          state_nx = RD_H;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides every handshake decided above.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      addr_nx  = addr;
      cap_h    = 1'b0;
      cap_m    = 1'b0;
      cap_l    = 1'b0;
      cap_w    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = err;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      rd_req     <= 1'b0;
      rd_exp     <= 2'd0;
      rd_addr    <= '0;
      pix_high   <= '0;
      pix_mid    <= '0;
      pix_low    <= '0;
      hdr_start  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      rd_req     <= (state_nx == RD_H) || (state_nx == RD_M) || (state_nx == RD_L);
      rd_exp     <= (state_nx == RD_M) ? 2'd1 : (state_nx == RD_L) ? 2'd2 : 2'd0;
      rd_addr    <= addr_nx;
      hdr_start  <= (state_nx == START);
      wr_valid   <= (state_nx == WRITE);
      busy       <= (state_nx != IDLE);
      frame_done <= done_nx;
      err        <= err_nx;
      if (cap_h) pix_high <= rd_data;
      if (cap_m) pix_mid  <= rd_data;
      if (cap_l) pix_low  <= rd_data;
      if (cap_w) begin
        wr_data <= hdr_le;
        wr_addr <= addr;
      end
    end
  end

`ifdef HDR_CTRL_TIMEOUT_EN
  // cnt equals the number of cycles elapsed since hdr_start rose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 4'd0;
    else if (state == START)
      cnt <= 4'd1;
    else if (state == WAIT)
      cnt <= cnt + 4'd1;
    else
      cnt <= 4'd0;
  end
`endif

endmodule

// File: tb/tb_hdr_ctrl.sv
// Scoreboard bench for hdr_ctrl on a 2x2 frame; covers the watchdog when HDR_CTRL_TIMEOUT_EN is defined.
module tb_hdr_ctrl;

  localparam int HR = 2;
  localparam int VR = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          abort = 1'b0;
  logic          rd_req;
  logic [1:0]    rd_exp;
  logic [AW-1:0] rd_addr;
  logic          rd_ack = 1'b0;
  logic [15:0]   rd_data = '0;
  logic [15:0]   pix_high, pix_mid, pix_low;
  logic          hdr_start;
  logic          hdr_done = 1'b0;
  logic [23:0]   hdr_le = '0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_ready = 1'b0;
  logic          busy, frame_done, err;

  int checks = 0;
  int failures = 0;
  int wr_accepts = 0;
  int done_count = 0;

  logic [47:0] pix_q[$];
  logic [25:0] wr_q[$];

  hdr_ctrl #(.H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
    .rd_req(rd_req), .rd_exp(rd_exp), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .pix_high(pix_high), .pix_mid(pix_mid), .pix_low(pix_low),
    .hdr_start(hdr_start), .hdr_done(hdr_done), .hdr_le(hdr_le),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Independent tally of accepted writes and frame_done cycles.
  always @(posedge clk) begin
    if (wr_valid && wr_ready) wr_accepts++;
    if (frame_done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      0:       return rd_req;
      1:       return hdr_start;
      default: return wr_valid;
    endcase
  endfunction

  task automatic waitSig(input int which, input string tag);
    int n = 0;
    while (!sigSel(which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sigSel(which)) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic serveRead(input logic [1:0] exp, input int dly, input logic [AW-1:0] a,
                           output logic [15:0] data);
    waitSig(0, "rd_req_wait");
    for (int i = 0; i < dly; i++) begin
      checkOutput("rd_req_held", rd_req, 1);
      checkOutput("rd_exp_held", rd_exp, exp);
      checkOutput("rd_addr_held", rd_addr, a);
      @(negedge clk);
    end
    checkOutput("rd_exp", rd_exp, exp);
    checkOutput("rd_addr", rd_addr, a);
    data    = 16'($urandom);
    rd_data = data;
    rd_ack  = 1'b1;
    @(negedge clk);
    rd_ack  = 1'b0;
    rd_data = 16'($urandom);
  endtask

  task automatic readPixel(input logic [AW-1:0] a, input int rdm_dly);
    logic [15:0] h, m, l;
    serveRead(2'd0, 0, a, h);
    serveRead(2'd1, rdm_dly, a, m);
    serveRead(2'd2, 0, a, l);
    pix_q.push_back({h, m, l});
    waitSig(1, "hdr_start_wait");
    if (pix_q.size() > 0) begin
      logic [47:0] p;
      p = pix_q.pop_front();
      checkOutput("pix_high", pix_high, p[47:32]);
      checkOutput("pix_mid", pix_mid, p[31:16]);
      checkOutput("pix_low", pix_low, p[15:0]);
    end
    @(negedge clk);
    checkOutput("hdr_start_pulse", hdr_start, 0);
  endtask

  task automatic servePixel(input logic [AW-1:0] a, input int rdm_dly, input int wr_dly,
                            input bit pulse_start, input bit last, input bit coin_start);
    logic [23:0] le;
    logic [25:0] e;
    int acc0;
    readPixel(a, rdm_dly);
    for (int i = 0; i < 2; i++) begin
      if (pulse_start && i == 0) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    le       = 24'($urandom);
    hdr_le   = le;
    hdr_done = 1'b1;
    wr_q.push_back({a, le});
    @(negedge clk);
    hdr_done = 1'b0;
    waitSig(2, "wr_valid_wait");
    e    = wr_q[0];
    acc0 = wr_accepts;
    for (int i = 0; i < wr_dly; i++) begin
      checkOutput("wr_valid_held", wr_valid, 1);
      checkOutput("wr_addr_held", wr_addr, e[25:24]);
      checkOutput("wr_data_held", wr_data, e[23:0]);
      @(negedge clk);
    end
    checkOutput("wr_addr", wr_addr, e[25:24]);
    checkOutput("wr_data", wr_data, e[23:0]);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    void'(wr_q.pop_front());
    checkOutput("one_write", wr_accepts, acc0 + 1);
    checkOutput("frame_done", frame_done, last);
    checkOutput("busy_after_write", busy, !last);
    if (last) begin
      if (coin_start) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checkOutput("frame_done_pulse", frame_done, 0);
      if (coin_start) begin
        @(negedge clk);
        checkOutput("coin_start_busy", busy, 0);
        checkOutput("coin_start_rd_req", rd_req, 0);
      end
    end
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("busy_start", busy, 1);
  endtask

  task automatic applyStimulus(input int rdm_dly0, input int wr_dly0, input bit pulse1, input bit coin);
    int d0;
    d0 = done_count;
    startFrame();
    for (int p = 0; p < HR * VR; p++)
      servePixel(AW'(p), (p == 0) ? rdm_dly0 : 0, (p == 0) ? wr_dly0 : 0,
                 pulse1 && (p == 1), p == HR * VR - 1, coin && (p == HR * VR - 1));
    checkOutput("frame_done_count", done_count, d0 + 1);
  endtask

  initial begin
    #200000;
    checkOutput("watchdog", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int wa, fd;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_req", rd_req, 0);
    checkOutput("rst_rd_exp", rd_exp, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_hdr_start", hdr_start, 0);
    checkOutput("rst_wr_valid", wr_valid, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_pix", {pix_high, pix_mid}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero-wait frame");
    applyStimulus(0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] stalled read/write, start while busy, start at frame_done");
    applyStimulus(5, 7, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    $display("[TB] abort in WAIT at pixel 1");
    startFrame();
    servePixel(AW'(0), 0, 0, 1'b0, 1'b0, 1'b0);
    readPixel(AW'(1), 0);
    wa = wr_accepts;
    fd = done_count;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wr_valid", wr_valid, 0);
    checkOutput("abort_hdr_start", hdr_start, 0);
    repeat (5) @(negedge clk);
    checkOutput("abort_rd_req", rd_req, 0);
    checkOutput("abort_no_write", wr_accepts, wa);
    checkOutput("abort_no_done", done_count, fd);
    applyStimulus(0, 0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset in WRITE");
    startFrame();
    readPixel(AW'(0), 0);
    @(negedge clk);
    hdr_le   = 24'h5a5a5a;
    hdr_done = 1'b1;
    @(negedge clk);
    hdr_done = 1'b0;
    waitSig(2, "wr_valid_wait_rst");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr_valid", wr_valid, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rd_req", rd_req, 0);
    checkOutput("post_rst_pix_high", pix_high, 0);
    applyStimulus(0, 0, 1'b0, 1'b0);

`ifdef HDR_CTRL_TIMEOUT_EN
    $display("[TB] HDR core timeout");
    startFrame();
    readPixel(AW'(0), 0);
    for (int k = 1; k < 15; k++) begin
      checkOutput("err_early", err, 0);
      @(negedge clk);
    end
    checkOutput("err_at_15", err, 1);
    checkOutput("timeout_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", err, 1);
    applyStimulus(0, 0, 1'b0, 1'b0);
    checkOutput("err_sticky_frame", err, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
`else
    checkOutput("err_const", err, 0);
`endif

    checkOutput("wr_q_empty", wr_q.size(), 0);
    checkOutput("pix_q_empty", pix_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
